sram_port_ctrl: RTL and testbench
=================================

Name: sram_port_ctrl

Overview:
- Synchronous initiator for one port of the 128x512 dual-port SRAM macro (active-low CSB/WEB/OEB, posedge CE, 7-bit address).
- Accepts burst read/write commands from the Winograd datapath, sequences per-word SRAM accesses with auto-incrementing address, and returns read data over a valid/ready channel.
- Read data passes through a small response FIFO so datapath backpressure never drops SRAM data.
- One instance per SRAM port; the SRAM CE pin is tied to clk.

Parameters:
- ADDR_W, 7, SRAM address width.
- DATA_W, 512, SRAM word width.
- RSP_DEPTH, 4, response FIFO depth (power of 2, >=2).

Ports:
- clk  in  1  system clock; also drives SRAM CE.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_write  in  1  1=write burst, 0=read burst.
- cmd_addr  in  ADDR_W  start address.
- cmd_len  in  ADDR_W  burst length minus 1 (0..127 means 1..128 words).
- wr_valid  in  1  write data valid.
- wr_ready  out  1  write word consumed.
- wr_data  in  DATA_W  write word.
- rd_valid  out  1  read word available.
- rd_ready  in  1  consumer accepts.
- rd_data  out  DATA_W  read word.
- rd_last  out  1  final word of burst.
- sram_csb  out  1  chip select, active low.
- sram_web  out  1  write enable, active low.
- sram_oeb  out  1  output enable, active low.
- sram_a  out  ADDR_W  address.
- sram_i  out  DATA_W  write data.
- sram_o  in  DATA_W  read data from SRAM.

Behaviour:
- Reset values: cmd_ready=0 (1 from first cycle after reset), wr_ready=0, rd_valid=0, rd_last=0, rd_data=0, sram_csb=1, sram_web=1, sram_oeb=1, sram_a=0, sram_i=0, FIFO empty.
- Reset mid-burst aborts the burst; FIFO contents are discarded; no SRAM access is issued while rst_n=0.
- FSM states: IDLE, WR, RD.
  - IDLE: cmd_ready=1. On handshake, latch addr and len into cnt, then go to WR or RD.
  - WR: wr_ready=1. On each wr handshake, register sram_csb=0, sram_web=0, sram_a=addr, sram_i=wr_data; the SRAM writes on the next posedge. Without a handshake, sram_csb=1 (idle bubble).
  - RD: issue one read per cycle (sram_csb=0, sram_web=1) only when fifo_count + inflight < RSP_DEPTH; otherwise sram_csb=1.
  - All outputs to the SRAM are registered.
- Address: increments by 1 per issued word; wraps 127->0 (mod 2^ADDR_W).
- Burst end: burst ends when the word with cnt==0 is issued; return to IDLE the next cycle. cmd_ready is asserted in IDLE only, so back-to-back bursts have exactly one IDLE cycle between them.
- Read pipeline timing:
  - Issue registered at edge N.
  - SRAM latches data_out at edge N+1.
  - sram_oeb=0 is registered for the cycle after edge N+1.
  - sram_o is captured into the FIFO at edge N+2.
  - rd_valid is visible 2 cycles after the issue edge when the FIFO was empty.
- inflight counts issued-not-captured reads (0..2). The last word captured carries a last tag, which appears as rd_last.
- FIFO:
  - rd_valid = !empty; rd_data and rd_last come from the head entry (first-word fall-through).
  - Simultaneous push and pop are allowed and leave the count unchanged.
  - Overflow cannot occur because of the issue throttle; an assertion checks this.
- A read command may be accepted while the FIFO still holds data from a prior burst; ordering is preserved.
- wr_data is ignored in RD/IDLE. rd_ready is don't-care when rd_valid=0.

Optional Feature:
- Macro: SRAM_PORT_CTRL_PERF_EN.
- With the macro defined:
  - Adds outputs perf_rd_cnt[31:0], perf_wr_cnt[31:0], perf_stall_cnt[31:0].
  - perf_rd_cnt and perf_wr_cnt count issued SRAM reads/writes.
  - perf_stall_cnt counts RD-state cycles throttled by a full FIFO.
  - Counters saturate at 2^32-1, reset to 0, and clear on perf_clr (added input, 1 bit, synchronous).
- Without the macro: none of these ports or registers exist; behaviour is otherwise identical.

Decomposition:
- Package sram_ctrl_pkg holds:
  - constants SRAM_ADDR_W=7, SRAM_DATA_W=512, SRAM_WORDS=128;
  - enum ctrl_state_t {IDLE, WR, RD}.
- One sub-module, sram_rsp_fifo: a parameterised synchronous FWFT FIFO of {last, data} with count output.

Test Plan:
- Single write addr=5 data=0xA5..A5, then read addr=5 len=0: SRAM sees csb=0/web=0 at a=5; rd_valid exactly 2 cycles after issue; rd_data=0xA5..A5; rd_last=1.
- Write burst addr=126 len=3 with incrementing data 1..4: SRAM addresses 126,127,0,1 in order. A read-back burst returns 1..4 with rd_last only on the 4th word.
- Read burst len=15 with rd_ready=0 for 20 cycles: at most RSP_DEPTH words are buffered and issue stalls. After rd_ready=1, all 16 words arrive in order with none lost.
- Write burst len=3 with wr_valid toggling 1,0,1,0...: sram_csb=0 only on handshake cycles; exactly 4 writes; FSM returns to IDLE.
- Assert rst_n=0 during the 3rd word of a read burst: all outputs return to reset values asynchronously. The next command executes cleanly with no stale rd_valid.
- Run with SRAM_PORT_CTRL_PERF_EN defined: after a write of len=7 and a read of len=7 with rd_ready held 0 for 10 cycles, perf_wr_cnt=8, perf_rd_cnt=8, and perf_stall_cnt>0.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared SRAM geometry constants and controller FSM state type.
package sram_ctrl_pkg;
   localparam int SRAM_ADDR_W = 7;
   localparam int SRAM_DATA_W = 512;
   localparam int SRAM_WORDS  = 128;
   typedef enum logic [1:0] {IDLE, WR, RD} ctrl_state_t;
endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: first-word-fall-through response FIFO with occupancy count.
module sram_rsp_fifo #(
   parameter int DW = 513,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_push,
   input  logic [DW-1:0] i_data,
   input  logic          i_pop,
   output logic [DW-1:0] o_data,
   output logic          o_empty,
   output logic [AW:0]   o_count
);
   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [AW:0]   r_cnt;
   assign o_empty = r_cnt == '0;
   assign o_count = r_cnt;
   assign o_data  = o_empty ? '0 : r_mem[r_rp];
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wp] <= i_data;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (i_push) r_wp <= r_wp + 1'b1;
         if (i_pop) r_rp <= r_rp + 1'b1;
         r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
      end
   end
   // The controller throttles reads so a push never lands on a full FIFO.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(i_push && !i_pop && r_cnt == (AW+1)'(DEPTH)));
endmodule

// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: burst initiator for one dual-port SRAM port with buffered read return.
// Define SRAM_PORT_CTRL_PERF_EN to add saturating read/write/stall performance counters.
module sram_port_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int ADDR_W = SRAM_ADDR_W,
   parameter int DATA_W = SRAM_DATA_W,
   parameter int RSP_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
`ifdef SRAM_PORT_CTRL_PERF_EN
   input  logic              perf_clr,
   output logic [31:0]       perf_rd_cnt,
   output logic [31:0]       perf_wr_cnt,
   output logic [31:0]       perf_stall_cnt,
`endif
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [ADDR_W-1:0] cmd_len,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
   output logic              sram_csb,
   output logic              sram_web,
   output logic              sram_oeb,
   output logic [ADDR_W-1:0] sram_a,
   output logic [DATA_W-1:0] sram_i,
   input  logic [DATA_W-1:0] sram_o
);
   localparam int CW = $clog2(RSP_DEPTH) + 1;
   ctrl_state_t       r_state;
   logic [ADDR_W-1:0] r_addr, r_cnt, r_a;
   logic [DATA_W-1:0] r_i;
   logic              r_cmd_ready, r_wr_ready, r_csb, r_web, r_oeb, r_iss_last, r_oeb_last;
   logic [CW-1:0]     w_count;
   logic [CW:0]       w_fill;
   logic [1:0]        w_inflight;
   logic              w_empty, w_pop, w_wr_hs, w_rd_iss, w_cmd_hs;
   logic [DATA_W:0]   w_head;
   // Reads in flight: one in the issue stage, one waiting for capture.
   assign w_inflight = {1'b0, !r_csb && r_web} + {1'b0, !r_oeb};
   assign w_fill     = (CW+1)'(w_count) + (CW+1)'(w_inflight);
   assign w_rd_iss   = r_state == RD && w_fill < (CW+1)'(RSP_DEPTH);
   assign w_wr_hs    = wr_valid && r_wr_ready;
   assign w_cmd_hs   = cmd_valid && r_cmd_ready;
   assign w_pop      = rd_ready && !w_empty;
   assign cmd_ready  = r_cmd_ready;
   assign wr_ready   = r_wr_ready;
   assign rd_valid   = !w_empty;
   assign {rd_last, rd_data} = w_head;
   assign sram_csb   = r_csb;
   assign sram_web   = r_web;
   assign sram_oeb   = r_oeb;
   assign sram_a     = r_a;
   assign sram_i     = r_i;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_cnt       <= '0;
         r_a         <= '0;
         r_i         <= '0;
         r_cmd_ready <= 1'b0;
         r_wr_ready  <= 1'b0;
         r_csb       <= 1'b1;
         r_web       <= 1'b1;
         r_oeb       <= 1'b1;
         r_iss_last  <= 1'b0;
         r_oeb_last  <= 1'b0;
      end else begin
         r_oeb      <= r_csb || !r_web;
         r_oeb_last <= r_iss_last;
         r_csb      <= !(w_wr_hs || w_rd_iss);
         r_web      <= !w_wr_hs;
         r_iss_last <= w_rd_iss && r_cnt == '0;
         if (w_wr_hs) r_i <= wr_data;
         if (r_state == IDLE) begin
            r_cmd_ready <= !w_cmd_hs;
            if (w_cmd_hs) begin
               r_addr     <= cmd_addr;
               r_cnt      <= cmd_len;
               r_wr_ready <= cmd_write;
               r_state    <= cmd_write ? WR : RD;
            end
         end else if (w_wr_hs || w_rd_iss) begin
            r_a    <= r_addr;
            r_addr <= r_addr + 1'b1;
            r_cnt  <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
               r_state     <= IDLE;
               r_cmd_ready <= 1'b1;
               r_wr_ready  <= 1'b0;
            end
         end
      end
   end
   sram_rsp_fifo #(.DW(DATA_W + 1), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (!r_oeb),
      .i_data  ({r_oeb_last, sram_o}),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_empty (w_empty),
      .o_count (w_count)
   );
`ifdef SRAM_PORT_CTRL_PERF_EN
   logic [31:0] r_perf_rd, r_perf_wr, r_perf_stall;
   assign perf_rd_cnt    = r_perf_rd;
   assign perf_wr_cnt    = r_perf_wr;
   assign perf_stall_cnt = r_perf_stall;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_rd    <= '0;
         r_perf_wr    <= '0;
         r_perf_stall <= '0;
      end else if (perf_clr) begin
         r_perf_rd    <= '0;
         r_perf_wr    <= '0;
         r_perf_stall <= '0;
      end else begin
         if (w_rd_iss && ~&r_perf_rd) r_perf_rd <= r_perf_rd + 1'b1;
         if (w_wr_hs && ~&r_perf_wr) r_perf_wr <= r_perf_wr + 1'b1;
         if (r_state == RD && !w_rd_iss && ~&r_perf_stall) r_perf_stall <= r_perf_stall + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_sram_port_ctrl.sv
// tb_sram_port_ctrl: directed bench for sram_port_ctrl with a behavioural SRAM model.
module tb_sram_port_ctrl;
   localparam int AW = 7;
   localparam int DW = 512;
   logic          clk = 1'b0, rst_n = 1'b0;
   logic          cmd_valid = 1'b0, cmd_write = 1'b0, cmd_ready;
   logic [AW-1:0] cmd_addr = '0, cmd_len = '0;
   logic          wr_valid = 1'b0, wr_ready;
   logic [DW-1:0] wr_data = '0;
   logic          rd_valid, rd_ready = 1'b0, rd_last;
   logic [DW-1:0] rd_data;
   logic          sram_csb, sram_web, sram_oeb;
   logic [AW-1:0] sram_a;
   logic [DW-1:0] sram_i, sram_o, r_dout;
`ifdef SRAM_PORT_CTRL_PERF_EN
   logic          perf_clr = 1'b0;
   logic [31:0]   perf_rd_cnt, perf_wr_cnt, perf_stall_cnt;
`endif
   logic [DW-1:0] mem [128];
   logic [AW-1:0] wa_q[$], ra_q[$];
   logic [DW-1:0] wd_q[$], rq_d[$], wq[$];
   logic          rq_l[$];
   int            n_cmp = 0, n_err = 0;
   localparam logic [DW-1:0] PAT_A5 = {64{8'hA5}};
   always #5 clk = ~clk;
   sram_port_ctrl dut (
      .clk(clk), .rst_n(rst_n),
`ifdef SRAM_PORT_CTRL_PERF_EN
      .perf_clr(perf_clr), .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt),
      .perf_stall_cnt(perf_stall_cnt),
`endif
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
      .sram_csb(sram_csb), .sram_web(sram_web), .sram_oeb(sram_oeb),
      .sram_a(sram_a), .sram_i(sram_i), .sram_o(sram_o)
   );
   // SRAM macro: synchronous on CE=clk, output visible only while OEB is low.
   always @(posedge clk) begin
      if (!sram_csb && !sram_web) begin
         mem[sram_a] <= sram_i;
         wa_q.push_back(sram_a);
         wd_q.push_back(sram_i);
      end
      if (!sram_csb && sram_web) begin
         r_dout <= mem[sram_a];
         ra_q.push_back(sram_a);
      end
      if (rd_valid && rd_ready) begin
         rq_d.push_back(rd_data);
         rq_l.push_back(rd_last);
      end
   end
   assign sram_o = sram_oeb ? '0 : r_dout;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [AW-1:0] l);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_len   = l;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (cmd_ready) break;
      end
      if (!cmd_ready) check("cmd_timeout", DW'(cmd_ready), DW'(1));
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic write_words(input bit toggle);
      for (int k = 0; k < wq.size(); k++) begin
         if (toggle && k > 0) begin
            wr_valid = 1'b0;
            @(posedge clk);
            #1 check("wr_bubble_csb", DW'(sram_csb), DW'(1));
         end
         wr_valid = 1'b1;
         wr_data  = wq[k];
         for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (wr_ready) break;
         end
         if (!wr_ready) check("wr_timeout", DW'(wr_ready), DW'(1));
         @(posedge clk);
         #1 wr_valid = 1'b0;
      end
   endtask

   task automatic wait_rd(input int n);
      for (int i = 0; i < 400 && rq_d.size() < n; i++) @(posedge clk);
      #1;
      if (rq_d.size() < n) check("rd_timeout", DW'(rq_d.size()), DW'(n));
   endtask

   task automatic load_wq(input int n, input int base);
      wq.delete();
      for (int k = 0; k < n; k++) wq.push_back(DW'(base + k));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [AW-1:0] ea [4];
      ea = '{7'd126, 7'd127, 7'd0, 7'd1};
      for (int k = 0; k < 128; k++) mem[k] = '0;
      r_dout = '0;
      #12;
      check("rst_ctrl", DW'({cmd_ready, wr_ready, rd_valid, rd_last, sram_csb, sram_web, sram_oeb}),
            DW'(7'b0000111));
      check("rst_a", DW'(sram_a), '0);
      check("rst_rd_data", rd_data, '0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("cmd_ready_pre", DW'(cmd_ready), '0);
      @(posedge clk);
      #1 check("cmd_ready_post", DW'(cmd_ready), DW'(1));

      // single write then single read with exact pipeline timing
      wq.delete();
      wq.push_back(PAT_A5);
      send_cmd(1'b1, 7'd5, 7'd0);
      write_words(1'b0);
      check("w1_csb_web", DW'({sram_csb, sram_web}), '0);
      check("w1_a", DW'(sram_a), DW'(5));
      check("w1_i", sram_i, PAT_A5);
      send_cmd(1'b0, 7'd5, 7'd0);
      @(posedge clk);
      #1 check("r1_issue", DW'({sram_csb, sram_web, sram_a, rd_valid}), DW'({1'b0, 1'b1, 7'd5, 1'b0}));
      @(posedge clk);
      #1 check("r1_oeb", DW'({sram_oeb, rd_valid}), '0);
      @(posedge clk);
      #1 check("r1_valid", DW'({rd_valid, rd_last}), DW'(2'b11));
      check("r1_data", rd_data, PAT_A5);
      rd_ready = 1'b1;
      @(posedge clk);
      #1 check("r1_drained", DW'(rd_valid), '0);

      // address wrap on write, then read back
      load_wq(4, 1);
      wa_q.delete();
      wd_q.delete();
      send_cmd(1'b1, 7'd126, 7'd3);
      write_words(1'b0);
      @(posedge clk);
      #1 check("w2_count", DW'(wa_q.size()), DW'(4));
      for (int k = 0; k < 4 && k < wa_q.size(); k++) begin
         check("w2_addr", DW'(wa_q[k]), DW'(ea[k]));
         check("w2_data", wd_q[k], DW'(k + 1));
      end
      rq_d.delete();
      rq_l.delete();
      send_cmd(1'b0, 7'd126, 7'd3);
      wait_rd(4);
      for (int k = 0; k < 4 && k < rq_d.size(); k++) begin
         check("r2_data", rq_d[k], DW'(k + 1));
         check("r2_last", DW'(rq_l[k]), DW'(k == 3));
      end

      // backpressure: 16-word read with consumer stalled
      load_wq(16, 100);
      send_cmd(1'b1, 7'd0, 7'd15);
      write_words(1'b0);
      rd_ready = 1'b0;
      ra_q.delete();
      rq_d.delete();
      rq_l.delete();
      send_cmd(1'b0, 7'd0, 7'd15);
      repeat (20) @(posedge clk);
      #1 check("r3_issued", DW'(ra_q.size()), DW'(4));
      check("r3_stall", DW'({rd_valid, sram_csb}), DW'(2'b11));
      rd_ready = 1'b1;
      wait_rd(16);
      for (int k = 0; k < 16 && k < rq_d.size(); k++) begin
         check("r3_data", rq_d[k], DW'(100 + k));
         check("r3_last", DW'(rq_l[k]), DW'(k == 15));
      end

      // write burst with gapped write data
      load_wq(4, 7);
      send_cmd(1'b1, 7'd20, 7'd3);
      wa_q.delete();
      write_words(1'b1);
      check("w4_idle", DW'({cmd_ready, wr_ready}), DW'(2'b10));
      @(posedge clk);
      #1 check("w4_count", DW'(wa_q.size()), DW'(4));
      if (wa_q.size() == 4) check("w4_last_addr", DW'(wa_q[3]), DW'(23));

      // asynchronous reset in the middle of a read burst
      rd_ready = 1'b1;
      ra_q.delete();
      send_cmd(1'b0, 7'd0, 7'd7);
      for (int i = 0; i < 60 && ra_q.size() < 2; i++) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check("r5_rst_ctrl", DW'({cmd_ready, wr_ready, rd_valid, rd_last, sram_csb, sram_web, sram_oeb}),
               DW'(7'b0000111));
      check("r5_rst_data", rd_data, '0);
      ra_q.delete();
      wa_q.delete();
      repeat (2) @(posedge clk);
      #1 check("r5_no_access", DW'(ra_q.size() + wa_q.size()), '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 check("r5_no_stale", DW'(rd_valid), '0);
      rq_d.delete();
      rq_l.delete();
      send_cmd(1'b0, 7'd21, 7'd1);
      wait_rd(2);
      if (rq_d.size() >= 2) begin
         check("r5_data0", rq_d[0], DW'(8));
         check("r5_data1", rq_d[1], DW'(9));
         check("r5_last", DW'({rq_l[0], rq_l[1]}), DW'(2'b01));
      end

`ifdef SRAM_PORT_CTRL_PERF_EN
      perf_clr = 1'b1;
      @(posedge clk);
      #1 perf_clr = 1'b0;
      check("perf_clr", DW'(perf_wr_cnt), '0);
      load_wq(8, 200);
      send_cmd(1'b1, 7'd40, 7'd7);
      write_words(1'b0);
      rd_ready = 1'b0;
      rq_d.delete();
      rq_l.delete();
      send_cmd(1'b0, 7'd40, 7'd7);
      repeat (10) @(posedge clk);
      #1 rd_ready = 1'b1;
      wait_rd(8);
      check("perf_wr", DW'(perf_wr_cnt), DW'(8));
      check("perf_rd", DW'(perf_rd_cnt), DW'(8));
      check("perf_stall_nz", DW'(perf_stall_cnt != 0), DW'(1));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
